// File: rtl/uart_pkg.sv
// Shared types and line levels for the byte UART transmitter.
// Optional parity stage is controlled by the UART_TX_PARITY_EN macro.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;
   localparam logic LINE_IDLE  = 1'b1;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter: registered storage, wrapping pointers,
// occupancy count. Read data is the current head so a pop can latch it directly.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem_reg [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push;
   logic          pop;

   // Readiness depends only on occupancy, never on a same-cycle pop.
   assign wr_ready = (count_reg != CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign rd_data  = mem_reg[rd_ptr_reg];
   assign push     = wr_valid && wr_ready;
   assign pop      = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_byte_tx.sv
// Queued 8N1 UART transmitter with per-frame latched baud divisor.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   tx_state_t        state_reg, state_next;
   logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
   logic [DIV_W-1:0] div_lat_reg, div_lat_next;
   logic [2:0]       bit_cnt_reg, bit_cnt_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_reg;
`ifdef UART_TX_PARITY_EN
   logic             par_reg, par_next;
`endif
   logic             fifo_empty;
   logic [7:0]       fifo_rd_data;
   logic             can_load;
   logic             load;
   logic             bit_end;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (tx_data),
      .wr_valid (tx_valid),
      .wr_ready (tx_ready),
      .rd_en    (load),
      .rd_data  (fifo_rd_data),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign can_load = ena && !fifo_empty;
   assign bit_end  = (div_cnt_reg == div_lat_reg);
   assign tx       = tx_reg;
   assign busy     = (state_reg != IDLE) || !fifo_empty;

   always_comb begin
      state_next   = state_reg;
      div_cnt_next = div_cnt_reg;
      div_lat_next = div_lat_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
`ifdef UART_TX_PARITY_EN
      par_next     = par_reg;
`endif
      load         = 1'b0;

      if (state_reg != IDLE) begin
         div_cnt_next = bit_end ? '0 : div_cnt_reg + DIV_W'(1);
      end

      case (state_reg)
         IDLE:  load = can_load;
         START: if (bit_end) state_next = DATA;
         DATA: begin
            if (bit_end) begin
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_next = STOP;
`endif
         STOP: begin
            // Chain straight into the next queued frame without an idle bit.
            if (bit_end) begin
               if (can_load) load = 1'b1;
               else          state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (load) begin
         state_next   = START;
         shift_next   = fifo_rd_data;
         div_lat_next = baud_div;
         div_cnt_next = '0;
         bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
         par_next     = even_parity(fifo_rd_data);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         div_cnt_reg <= '0;
         div_lat_reg <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
         par_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         div_cnt_reg <= div_cnt_next;
         div_lat_reg <= div_lat_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
`ifdef UART_TX_PARITY_EN
         par_reg     <= par_next;
`endif
         // Line level follows the state one clock later, so every bit keeps its full width.
         case (state_reg)
            START:   tx_reg <= LINE_START;
            DATA:    tx_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_reg <= par_reg;
`endif
            default: tx_reg <= LINE_STOP;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frame-level reference model checked
// every cycle, plus directed literal checks of reset, timing and flow control.
module tb_uart_byte_tx;

   localparam int DEPTH = 4;
   localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     ena = 1'b0;
   logic [DIV_W-1:0]         baud_div = '0;
   logic [7:0]               tx_data = '0;
   logic                     tx_valid = 1'b0;
   logic                     tx_ready;
   logic                     tx;
   logic                     busy;
   logic [$clog2(DEPTH):0]   fifo_count;

   always #5 clk = ~clk;

   uart_byte_tx #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .baud_div   (baud_div),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line level of bit k of a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Reference model: queue of bytes, queue of expected line samples per clock.
   logic [7:0] mq[$];
   logic       lq[$];
   int         frame_rem = 0;
   bit         model_live = 1'b0;
   logic       exp_tx = 1'b1;
   bit         m_push;
   logic [7:0] m_byte;
   int         m_span;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         lq.delete();
         frame_rem  = 0;
         exp_tx     = 1'b1;
         model_live = 1'b1;
      end else if (model_live) begin
         m_push = tx_valid && (mq.size() < DEPTH);
         exp_tx = (lq.size() > 0) ? lq.pop_front() : 1'b1;
         if (frame_rem > 0) frame_rem--;
         if (frame_rem == 0 && ena && mq.size() > 0) begin
            m_byte    = mq.pop_front();
            m_span    = int'(baud_div) + 1;
            frame_rem = NBITS * m_span;
            for (int k = 0; k < NBITS; k++)
               for (int r = 0; r < m_span; r++)
                  lq.push_back(frame_bit(m_byte, k));
            $display("frame start: byte %02h, %0d clocks/bit", m_byte, m_span);
         end
         if (m_push) mq.push_back(tx_data);
      end
      #1;
      if (model_live) begin
         chk("tx", 32'(tx), 32'(exp_tx));
         chk("tx_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
         chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
         chk("busy", 32'(busy), 32'(frame_rem > 0 || mq.size() > 0));
      end
   end

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   logic [10:0] lit_bits;

   initial begin
      // Reset held for two edges
      rst_n = 1'b0; ena = 1'b1; baud_div = 16'd3;
      repeat (2) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single frame 0xA5 at 4 clocks/bit
`ifdef UART_TX_PARITY_EN
      lit_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
      lit_bits = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
      tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("accept_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      chk("pre_start_tx", 32'(tx), 32'd1);
      @(negedge clk);
      chk("start_edge_tx", 32'(tx), 32'd0);
      @(negedge clk);
      for (int k = 0; k < NBITS; k++) begin
         if (k > 0) repeat (4) @(negedge clk);
         chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(lit_bits[k]));
      end
      @(negedge clk);
      chk("frame_last_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("frame_len_busy", 32'(busy), 32'd0);
      wait_idle(200);

      // Back-pressure with ena low, then back-to-back drain
      ena = 1'b0; baud_div = 16'd1;
      for (int i = 0; i < 5; i++) begin
         tx_data = 8'($urandom); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      chk("bp_ready", 32'(tx_ready), 32'd0);
      chk("bp_count", 32'(fifo_count), 32'd4);
      ena = 1'b1;
      wait_idle(500);

      // Reset during data bit 3
      baud_div = 16'd7;
      tx_data = 8'h3C; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (2 + 8 * 4 + 3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      repeat (100) @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Divisor changes mid-frame take effect on the next frame only
      baud_div = 16'd0;
      tx_data = 8'hFF; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'h55;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      baud_div = 16'd9;
      wait_idle(1000);

      // ena dropped during DATA with two bytes still queued
      baud_div = 16'd2;
      for (int i = 0; i < 3; i++) begin
         tx_data = 8'($urandom); tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      ena = 1'b0;
      chk("ena_drop_count", 32'(fifo_count), 32'd2);
      repeat (60) @(negedge clk);
      chk("ena_hold_count", 32'(fifo_count), 32'd2);
      chk("ena_hold_tx", 32'(tx), 32'd1);
      chk("ena_hold_busy", 32'(busy), 32'd1);
      ena = 1'b1;
      wait_idle(500);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         tx_valid = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         ena      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 3));
         rst_n    = ($urandom_range(0, 499) != 0);
         @(negedge clk);
      end
      tx_valid = 1'b0; ena = 1'b1; rst_n = 1'b1;
      wait_idle(3000);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
